// File: rtl/ps2_keyboard_decoder.sv
// PS/2 keyboard receiver: oversamples the PS/2 lines, deframes 11-bit odd-parity
// frames, tracks E0/F0 prefixes and turns game-key make codes into command pulses.
module ps2_keyboard_decoder #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [2:0] keyboard_signal,
  output logic [7:0] scan_code,
  output logic       frame_error
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t         state, stateNext;
  logic           clkMeta, clkSync, clkPrev;
  logic           dataMeta, dataSync;
  logic           fe;
  logic [9:0]     shiftReg;
  logic [3:0]     bitCount;
  logic [CW-1:0]  timeoutCount;
  logic           extFlag, brkFlag;
  logic           extNext, brkNext;
  logic [2:0]     cmdNext;
  logic [7:0]     scanNext;
  logic           errNext;
  logic           frameGood;
  logic [7:0]     frameByte;

  function automatic logic [2:0] lookup(input logic ext, input logic [7:0] code);
    logic [2:0] cmd;
    cmd = 3'b000;
    if (ext) begin
      case (code)
        8'h75:   cmd = 3'b111;
        8'h6B:   cmd = 3'b101;
        8'h74:   cmd = 3'b110;
        8'h72:   cmd = 3'b100;
        default: cmd = 3'b000;
      endcase
    end else begin
      case (code)
        8'h1D:   cmd = 3'b111;
        8'h1C:   cmd = 3'b101;
        8'h23:   cmd = 3'b110;
        8'h1B:   cmd = 3'b100;
        8'h29:   cmd = 3'b111;
        default: cmd = 3'b000;
      endcase
    end
    return cmd;
  endfunction

  assign fe        = clkPrev & ~clkSync;
  // Received bits sit LSB-first: [7:0] data, [8] parity, [9] stop.
  assign frameByte = shiftReg[7:0];
  assign frameGood = (^shiftReg[8:0]) & shiftReg[9];

  always_comb begin
    stateNext = state;
    extNext   = extFlag;
    brkNext   = brkFlag;
    cmdNext   = 3'b000;
    scanNext  = scan_code;
    errNext   = 1'b0;
    case (state)
      IDLE: begin
        if (fe && !dataSync) stateNext = RECV;
      end
      RECV: begin
        if (fe) begin
          if (bitCount == 4'd9) stateNext = CHECK;
        end else if (timeoutCount == CW'(TIMEOUT_CYCLES - 1)) begin
          stateNext = IDLE;
          errNext   = 1'b1;
          extNext   = 1'b0;
          brkNext   = 1'b0;
        end
      end
      CHECK: begin
        stateNext = IDLE;
        if (frameGood) begin
          scanNext = frameByte;
          if (frameByte == 8'hE0) begin
            extNext = 1'b1;
          end else if (frameByte == 8'hF0) begin
            brkNext = 1'b1;
          end else begin
            if (!brkFlag) cmdNext = lookup(extFlag, frameByte);
            extNext = 1'b0;
            brkNext = 1'b0;
          end
        end else begin
          errNext = 1'b1;
          extNext = 1'b0;
          brkNext = 1'b0;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      clkMeta         <= 1'b1;
      clkSync         <= 1'b1;
      clkPrev         <= 1'b1;
      dataMeta        <= 1'b1;
      dataSync        <= 1'b1;
      shiftReg        <= '0;
      bitCount        <= '0;
      timeoutCount    <= '0;
      extFlag         <= 1'b0;
      brkFlag         <= 1'b0;
      keyboard_signal <= 3'b000;
      scan_code       <= 8'h00;
      frame_error     <= 1'b0;
    end else begin
      state           <= stateNext;
      clkMeta         <= ps2_clk;
      clkSync         <= clkMeta;
      clkPrev         <= clkSync;
      dataMeta        <= ps2_data;
      dataSync        <= dataMeta;
      extFlag         <= extNext;
      brkFlag         <= brkNext;
      keyboard_signal <= cmdNext;
      scan_code       <= scanNext;
      frame_error     <= errNext;
      if (state == IDLE && fe && !dataSync) bitCount <= '0;
      else if (state == RECV && fe)        bitCount <= bitCount + 4'd1;
      if (state == RECV && fe) shiftReg <= {dataSync, shiftReg[9:1]};
      // Idle time is only measured while a frame is in flight.
      if (state != RECV || fe) timeoutCount <= '0;
      else                     timeoutCount <= timeoutCount + CW'(1);
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Bench for ps2_keyboard_decoder: directed scenarios plus random frames, scored
// against a key-table model of the keyboard protocol.
module tb_ps2_keyboard_decoder;

  localparam int TO = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [2:0] keyboard_signal;
  logic [7:0] scan_code;
  logic       frame_error;

  ps2_keyboard_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keyboard_signal(keyboard_signal), .scan_code(scan_code), .frame_error(frame_error)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // monitor: collects every command pulse and error pulse
  logic [2:0] obs_q[$];
  int         obs_cyc[$];
  int         err_seen = 0;
  int         err_cyc = 0;
  int         width_err = 0;
  logic [2:0] prev_cmd = 3'b000;
  logic       prev_err = 1'b0;

  always @(negedge clk) begin
    if (keyboard_signal != 3'b000) begin
      obs_q.push_back(keyboard_signal);
      obs_cyc.push_back(cycle);
      if (prev_cmd != 3'b000) width_err++;
    end
    if (frame_error) begin
      err_seen++;
      err_cyc = cycle;
      if (prev_err) width_err++;
    end
    prev_cmd = keyboard_signal;
    prev_err = frame_error;
  end

  // reference model: keyboard protocol at byte level
  logic [2:0] ext_map[logic [7:0]];
  logic [2:0] base_map[logic [7:0]];
  logic [2:0] exp_q[$];
  logic       m_ext = 1'b0;
  logic       m_brk = 1'b0;
  logic [7:0] m_scan = 8'h00;
  logic       exp_err = 1'b0;

  task automatic model_frame(input logic [7:0] b, input logic bad);
    if (bad) begin
      m_ext = 1'b0; m_brk = 1'b0; exp_err = 1'b1;
    end else begin
      m_scan = b;
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
        if (!m_brk) begin
          if (m_ext && ext_map.exists(b)) exp_q.push_back(ext_map[b]);
          else if (!m_ext && base_map.exists(b)) exp_q.push_back(base_map[b]);
        end
        m_ext = 1'b0; m_brk = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    m_ext = 1'b0; m_brk = 1'b0; m_scan = 8'h00;
  endtask

  // drivers
  int last_fe = 0;

  task automatic send_bit(input logic v);
    @(negedge clk) ps2_data = v;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    last_fe = cycle;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic settle_and_check(input string tag, input int ref_cyc, input int lat_lo, input int lat_hi);
    repeat (8) @(negedge clk);
    check({tag, "_ncmd"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [2:0] o, e;
      int oc;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      oc = obs_cyc.pop_front();
      check({tag, "_cmd"}, o, e);
      check({tag, "_cmd_lat"}, oc - ref_cyc, 4);
    end
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    check({tag, "_err"}, err_seen, exp_err);
    if (exp_err && err_seen == 1)
      check({tag, "_err_lat"}, (err_cyc - ref_cyc >= lat_lo && err_cyc - ref_cyc <= lat_hi), 1);
    err_seen = 0;
    exp_err = 1'b0;
    check({tag, "_scan"}, scan_code, m_scan);
  endtask

  task automatic send_frame(input string tag, input logic [7:0] b, input logic flip_par, input logic bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ flip_par);
    send_bit(~bad_stop);
    @(negedge clk) ps2_data = 1'b1;
    model_frame(b, flip_par | bad_stop);
    settle_and_check(tag, last_fe, 4, 4);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_kbd"}, keyboard_signal, 3'b000);
    check({tag, "_scan"}, scan_code, 8'h00);
    check({tag, "_ferr"}, frame_error, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pool[12];
    logic [7:0] b;
    ext_map[8'h75] = 3'b111; ext_map[8'h6B] = 3'b101;
    ext_map[8'h74] = 3'b110; ext_map[8'h72] = 3'b100;
    base_map[8'h1D] = 3'b111; base_map[8'h1C] = 3'b101; base_map[8'h23] = 3'b110;
    base_map[8'h1B] = 3'b100; base_map[8'h29] = 3'b111;
    pool = '{8'hE0, 8'hF0, 8'h75, 8'h6B, 8'h74, 8'h72, 8'h1D, 8'h1C, 8'h23, 8'h1B, 8'h29, 8'h00};

    // reset with toggling lines
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ps2_clk = 1'($urandom_range(0, 1));
      ps2_data = 1'($urandom_range(0, 1));
      if (i > 0) check_idle_outputs("reset_hold");
    end
    @(negedge clk);
    ps2_clk = 1'b1; ps2_data = 1'b1; rst = 1'b1;
    repeat (20) @(negedge clk);
    check_idle_outputs("after_reset");
    check("after_reset_pulses", obs_q.size() + err_seen, 0);
    obs_q.delete(); obs_cyc.delete(); err_seen = 0;

    // extended make
    send_frame("ext_e0", 8'hE0, 1'b0, 1'b0);
    send_frame("ext_6b", 8'h6B, 1'b0, 1'b0);

    // break suppression
    send_frame("brk_1d", 8'h1D, 1'b0, 1'b0);
    send_frame("brk_f0", 8'hF0, 1'b0, 1'b0);
    send_frame("brk_1d2", 8'h1D, 1'b0, 1'b0);
    send_frame("brk_e0", 8'hE0, 1'b0, 1'b0);
    send_frame("brk_f0b", 8'hF0, 1'b0, 1'b0);
    send_frame("brk_72", 8'h72, 1'b0, 1'b0);

    // parity / stop errors, prefix dropped by an error
    send_frame("par_1c", 8'h1C, 1'b1, 1'b0);
    send_frame("good_1c", 8'h1C, 1'b0, 1'b0);
    send_frame("pre_e0", 8'hE0, 1'b0, 1'b0);
    send_frame("stop_bad", 8'h6B, 1'b0, 1'b1);
    send_frame("drop_6b", 8'h6B, 1'b0, 1'b0);
    send_frame("dup_e0a", 8'hE0, 1'b0, 1'b0);
    send_frame("dup_e0b", 8'hE0, 1'b0, 1'b0);
    send_frame("dup_75", 8'h75, 1'b0, 1'b0);

    // timeout: start + 4 data bits then stall
    b = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    @(negedge clk) ps2_data = 1'b1;
    repeat (TO + 2) @(negedge clk);
    exp_err = 1'b1;
    m_ext = 1'b0; m_brk = 1'b0;
    settle_and_check("timeout", last_fe, TO, TO + 6);
    send_frame("after_to_1b", 8'h1B, 1'b0, 1'b0);

    // typematic
    for (int i = 0; i < 3; i++) send_frame("typematic_1b", 8'h1B, 1'b0, 1'b0);

    // reset mid-frame during bit 5 of 23
    b = 8'h23;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(b[i]);
    @(negedge clk) ps2_data = b[5];
    repeat (2) @(negedge clk);
    rst = 1'b0; ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1; ps2_data = 1'b1; rst = 1'b1;
    model_reset();
    settle_and_check("rst_mid", last_fe, 4, 4);
    send_frame("after_rst_23", 8'h23, 1'b0, 1'b0);

    // random frames
    for (int n = 0; n < 40; n++) begin
      int sel;
      logic fp, bs;
      sel = $urandom_range(0, 11);
      b = (sel == 11) ? 8'($urandom_range(0, 255)) : pool[sel];
      fp = ($urandom_range(0, 9) == 0);
      bs = ($urandom_range(0, 14) == 0);
      send_frame("random", b, fp, bs);
    end

    check("pulse_width", width_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_decoder.md
Name: ps2_keyboard_decoder

Overview:
- PS/2 keyboard receiver feeding the game controller's 3-bit keyboard_signal command input.
- Oversamples ps2_clk/ps2_data in the system clock domain, deframes 11-bit PS/2 frames and checks odd parity.
- Tracks the E0 (extended) and F0 (break) prefixes and maps make codes of game keys to one-cycle command pulses.
- One pulse is produced per make code, so keyboard typematic repeat gives repeated moves.

Parameters:
- TIMEOUT_CYCLES, 100000: clk cycles without a ps2_clk falling edge mid-frame before the frame is aborted (1 ms at 100 MHz).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-low (asserted when 0).
- ps2_clk  input  1  raw PS/2 clock, asynchronous, idle high.
- ps2_data  input  1  raw PS/2 data, asynchronous, idle high.
- keyboard_signal  output  3  command: 000 idle, 100 down, 101 left, 110 right, 111 rotate. Non-idle for exactly one cycle per accepted make code.
- scan_code  output  8  last correctly received byte, including E0/F0.
- frame_error  output  1  one-cycle pulse on a parity, stop-bit or timeout error.

Behaviour:
- Reset (rst==0 at posedge clk):
  - keyboard_signal=000, scan_code=8'h00, frame_error=0.
  - FSM=IDLE; ext_flag=0, brk_flag=0; bit counter=0; timeout counter=0.
  - Synchronizer and edge registers preset to 1.
  - Reset mid-frame discards the partial frame; no pulse is emitted.
- Input conditioning:
  - Each of ps2_clk and ps2_data passes through a 2-flop synchronizer.
  - A falling edge (fe) is detected when the previous synchronized clk is 1 and the current one is 0.
  - All sampling of synchronized data happens only on fe cycles.
- Deframing FSM, IDLE -> RECV -> CHECK -> IDLE:
  - IDLE: on fe with data==0 (start bit), go to RECV with bit counter=0. On fe with data==1, stay in IDLE; no error.
  - RECV: each fe shifts data in LSB-first. Bits 0-7 are data, bit 8 is parity, bit 9 is stop. On the fe that samples stop, go to CHECK.
  - CHECK (one cycle): good frame = XOR(data, parity)==1 and stop==1.
    - Good frame: scan_code<=byte; run decode; go to IDLE.
    - Bad frame: frame_error=1 for this cycle; ext_flag and brk_flag cleared; go to IDLE.
- Timeout:
  - The counter runs in RECV and resets on every fe.
  - When it reaches TIMEOUT_CYCLES-1: frame_error pulse, go to IDLE, clear flags, no pulse.
- Decode (good frame only, in the CHECK cycle):
  - byte==E0: set ext_flag.
  - byte==F0: set brk_flag.
  - Otherwise: if brk_flag, no command; else look up the command. Clear both flags in either case.
  - Map with ext_flag=1: 75 -> 111, 6B -> 101, 74 -> 110, 72 -> 100.
  - Map with ext_flag=0: 1D(W) -> 111, 1C(A) -> 101, 23(D) -> 110, 1B(S) -> 100, 29(space) -> 111.
  - Any other byte produces no command.
- Latency and pulse shape:
  - keyboard_signal is registered. It is non-000 exactly in the cycle after CHECK, then returns to 000.
  - Stop-bit fe to command is 2 clk cycles, plus 2 synchronizer cycles.
- Boundaries:
  - A new start-bit fe in the CHECK cycle cannot occur, because PS/2 bit period far exceeds 1 clk.
  - Back-to-back frames are accepted with no dead time beyond CHECK.
  - Sequence E0 F0 75 produces no command and clears both flags.
  - An error or timeout between a prefix and its code drops the prefix.
  - Duplicate prefixes (E0 E0) are idempotent.
  - scan_code is held between frames and is not updated on a bad frame.

Test Plan:
- Reset: hold rst=0 for 3 cycles with lines toggling -> keyboard_signal=000, scan_code=00, frame_error=0, no pulse after release.
- Extended make: send frames E0 then 6B with correct parity -> exactly one cycle of keyboard_signal=101 after the second frame; scan_code=6B; frame_error never set.
- Break suppression: send 1D, then F0 1D, then E0 F0 72 -> only one 111 pulse (from the first 1D); scan_code=72 at end.
- Parity error: send byte 1C with parity bit inverted -> frame_error one-cycle pulse, keyboard_signal stays 000, scan_code unchanged; a following good 1C -> 101 pulse.
- Timeout: drive start plus 4 data bits, then stall ps2_clk high for TIMEOUT_CYCLES (set to 50) -> frame_error pulse at cycle 50; a subsequent full 1B frame -> 100 pulse.
- Typematic and reset mid-frame: send 1B three times -> three separate 100 pulses. Assert rst=0 during bit 5 of a 23 frame -> no 110 pulse; the next good 23 frame -> 110 pulse.
